pipeline_stall_ctrl: RTL

Responder side of the CPU hazard interface. It consumes data_hazard/control_hazard from the hazard detector and the decode-stage call/ret/branch flags. It drives pipeline stall, bubble and flush controls, and times and returns the one-cycle clr_call_haz/clr_ret_haz/clr_branch_haz pulses that release the detector's sticky control-hazard registers. It sits beside the decode stage, between the hazard detector and the IF/ID and ID/EX pipeline registers and the PC.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_stall_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: hazard-responder state encoding, NOP opcode and the
// default control-instruction latencies also used by the hazard detector bench.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BR   = 2'd1,
    WAIT_CALL = 2'd2,
    WAIT_RET  = 2'd3
  } stall_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam int DEF_BR_LAT   = 2;
  localparam int DEF_CALL_LAT = 3;
  localparam int DEF_RET_LAT  = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Hazard responder beside decode: stalls/bubbles on data hazards, freezes and
// flushes fetch for call/ret/branch, and pulses the detector's release lines.
module pipeline_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int BR_LAT   = DEF_BR_LAT,
  parameter int CALL_LAT = DEF_CALL_LAT,
  parameter int RET_LAT  = DEF_RET_LAT,
  parameter int CNT_W    = 3,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_hazard,
  input  logic              control_hazard,
  input  logic              call_id,
  input  logic              ret_id,
  input  logic              branch_id,
  input  logic              branch_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              idex_bubble,
  output logic              ifid_flush,
  output logic              pc_redirect,
  output logic              clr_call_haz,
  output logic              clr_ret_haz,
  output logic              clr_branch_haz,
  output logic              protocol_err,
  output logic [STAT_W-1:0] stall_cycles
);

  stall_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             release_cyc;
  logic             clr_any;
  logic             clr_d;
  logic             accept_d;

  assign accept      = (state == IDLE) && !data_hazard && (call_id || ret_id || branch_id);
  assign release_cyc = (state != IDLE) && (cnt == '0);
  assign clr_any     = clr_call_haz || clr_ret_haz || clr_branch_haz;

  // control_hazard is legitimately high in IDLE only while the detector is
  // still catching up with a release pulse or an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      clr_call_haz   <= 1'b0;
      clr_ret_haz    <= 1'b0;
      clr_branch_haz <= 1'b0;
      clr_d          <= 1'b0;
      accept_d       <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      clr_call_haz   <= release_cyc && (state == WAIT_CALL);
      clr_ret_haz    <= release_cyc && (state == WAIT_RET);
      clr_branch_haz <= release_cyc && (state == WAIT_BR);
      clr_d          <= clr_any;
      accept_d       <= accept;
      if ((state == IDLE) && control_hazard && !clr_any && !clr_d && !accept_d)
        protocol_err <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            if (call_id) begin
              state <= WAIT_CALL;
              cnt   <= CNT_W'(CALL_LAT - 1);
            end else if (ret_id) begin
              state <= WAIT_RET;
              cnt   <= CNT_W'(RET_LAT - 1);
            end else begin
              state <= WAIT_BR;
              cnt   <= CNT_W'(BR_LAT - 1);
            end
          end
        end
        default: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pc_redirect = 1'b0;
    if (state == IDLE) begin
      if (data_hazard) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_bubble = 1'b1;
      end
    end else begin
      // Decode holds only flushed NOPs here, so data_hazard is irrelevant.
      ifid_flush  = 1'b1;
      pc_stall    = !release_cyc;
      pc_redirect = release_cyc && ((state != WAIT_BR) || branch_taken);
    end
  end

  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (stall_cycles)
  );

endmodule
